listbuffer_param: RTL and testbench

Parametrised multi-list linked-list buffer: the successor to the fixed 4-beat put buffer in the L2 cache. It stores beats (data + byte mask) for up to `LISTS` independent FIFO lists in a shared pool of `BEATS` slots, linked through a `next` table. Compared with the fixed version it adds:
- arbitrary depth and width,
- true same-cycle push and pop, including to the same list,
- a free-slot count,
- a protocol-error flag for pops of an empty list.

It sits between the sink-A put path and the main pipe / source-D data return.

---
 rtl/listbuffer_pkg.sv | 17 +
 rtl/listbuffer_param_lowest_one_enc.sv | 13 +
 rtl/listbuffer_param.sv | 137 +++++++++++++
 tb/tb_listbuffer_param.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/listbuffer_pkg.sv
// Shared defaults for the L2 put-path linked-list buffer.
// Instances override listbuffer_param from these values.
package listbuffer_pkg;

    localparam int PUTLISTS  = 4;
    localparam int PUTBEATS  = 8;
    localparam int DATA_BITS = 256;
    localparam int MASK_BITS = 32;

    typedef enum logic [1:0] {
        EV_IDLE = 2'b00,
        EV_PUSH = 2'b01,
        EV_POP  = 2'b10,
        EV_BOTH = 2'b11
    } fill_ev_e;

endpackage

// File: rtl/listbuffer_param_lowest_one_enc.sv
// Lowest-set-bit one-hot isolation for an arbitrary width.
// Feeds the one-hot to binary conversion in the buffer.
module lowest_one_enc #(
    parameter int W = 8
) (
    input  logic [W-1:0] req,
    output logic [W-1:0] gnt
);

    // Two's complement trick: x & -x keeps only the lowest one.
    assign gnt = req & (~req + W'(1));

endmodule

// File: rtl/listbuffer_param.sv
// Multi-list linked-list beat buffer over a shared slot pool.
// Lists are FIFOs threaded through a per-slot next table.
module listbuffer_param
    import listbuffer_pkg::*;
#(
    parameter int LISTS  = PUTLISTS,
    parameter int BEATS  = PUTBEATS,
    parameter int DATA_W = DATA_BITS,
    parameter int MASK_W = MASK_BITS,
    parameter int LW = (LISTS > 1) ? $clog2(LISTS) : 1,
    parameter int BW = (BEATS > 1) ? $clog2(BEATS) : 1,
    parameter int CW = $clog2(BEATS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid_i,
    output logic              push_ready_o,
    input  logic [LW-1:0]     push_index_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic [MASK_W-1:0] push_mask_i,
    output logic [LISTS-1:0]  valid_o,
    input  logic              pop_valid_i,
    input  logic [LW-1:0]     pop_index_i,
    output logic [DATA_W-1:0] data_o,
    output logic [MASK_W-1:0] mask_o,
    output logic [CW-1:0]     free_count_o,
    output logic              pop_err_o
);

    logic [BEATS-1:0]  used_q;
    logic [BW-1:0]     next_q [BEATS];
    logic [DATA_W-1:0] data_q [BEATS];
    logic [MASK_W-1:0] mask_q [BEATS];
    logic [LISTS-1:0]  valid_q;
    logic [BW-1:0]     head_q [LISTS];
    logic [BW-1:0]     tail_q [LISTS];
    logic [CW-1:0]     free_q;
    logic              err_q;

    logic [BEATS-1:0] free_oh;
    logic [BW-1:0]    free_idx;
    logic [LISTS-1:0] push_dec;
    logic [LISTS-1:0] pop_dec;
    logic [BW-1:0]    head_sel;
    logic             push_fire;
    logic             pop_fire;
    fill_ev_e         ev;

    lowest_one_enc #(.W(BEATS)) u_enc (
        .req(~used_q),
        .gnt(free_oh)
    );

    always_comb begin
        free_idx = '0;
        for (int i = 0; i < BEATS; i++)
            if (free_oh[i]) free_idx = free_idx | BW'(i);
    end

    // Decoded selects keep out-of-range indices from aliasing a list.
    always_comb begin
        push_dec = '0;
        pop_dec  = '0;
        head_sel = '0;
        for (int l = 0; l < LISTS; l++) begin
            push_dec[l] = (push_index_i == LW'(l));
            pop_dec[l]  = (pop_index_i == LW'(l));
            if (pop_index_i == LW'(l)) head_sel = head_q[l];
        end
    end

    assign push_ready_o = ~&used_q;
    assign push_fire    = push_valid_i & push_ready_o;
    assign pop_fire     = pop_valid_i & |(valid_q & pop_dec);
    assign ev           = fill_ev_e'({pop_fire, push_fire});

    assign valid_o      = valid_q;
    assign data_o       = data_q[head_sel];
    assign mask_o       = mask_q[head_sel];
    assign free_count_o = free_q;
    assign pop_err_o    = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used_q  <= '0;
            valid_q <= '0;
            free_q  <= CW'(BEATS);
            err_q   <= 1'b0;
            for (int i = 0; i < BEATS; i++) begin
                next_q[i] <= '0;
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
            for (int l = 0; l < LISTS; l++) begin
                head_q[l] <= '0;
                tail_q[l] <= '0;
            end
        end else begin
            err_q <= pop_valid_i & ~pop_fire;
            unique case (ev)
                EV_PUSH: free_q <= free_q - CW'(1);
                EV_POP:  free_q <= free_q + CW'(1);
                default: free_q <= free_q;
            endcase
            if (push_fire) begin
                data_q[free_idx] <= push_data_i;
                mask_q[free_idx] <= push_mask_i;
                used_q[free_idx] <= 1'b1;
            end
            if (pop_fire) used_q[head_sel] <= 1'b0;
            for (int l = 0; l < LISTS; l++) begin
                if (pop_fire && pop_dec[l]) begin
                    if (head_q[l] == tail_q[l]) begin
                        if (!(push_fire && push_dec[l]))
                            valid_q[l] <= 1'b0;
                        else
                            head_q[l] <= free_idx;
                    end else begin
                        head_q[l] <= next_q[head_q[l]];
                    end
                end
                // Append; a single-entry list being popped restarts at the new slot.
                if (push_fire && push_dec[l]) begin
                    tail_q[l] <= free_idx;
                    if (!valid_q[l]) begin
                        head_q[l]  <= free_idx;
                        valid_q[l] <= 1'b1;
                    end else if (!(pop_fire && pop_dec[l]
                                   && head_q[l] == tail_q[l])) begin
                        next_q[tail_q[l]] <= free_idx;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_listbuffer_param.sv
// Randomized scoreboard bench for listbuffer_param.
module tb_listbuffer_param;

    localparam int LISTS = 4;
    localparam int BEATS = 8;
    localparam int DW = 256;
    localparam int MW = 32;

    typedef struct {
        logic [DW-1:0] d;
        logic [MW-1:0] m;
    } beat_t;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          push_valid_i = 0;
    logic          push_ready_o;
    logic [1:0]    push_index_i = 0;
    logic [DW-1:0] push_data_i = 0;
    logic [MW-1:0] push_mask_i = 0;
    logic [3:0]    valid_o;
    logic          pop_valid_i = 0;
    logic [1:0]    pop_index_i = 0;
    logic [DW-1:0] data_o;
    logic [MW-1:0] mask_o;
    logic [3:0]    free_count_o;
    logic          pop_err_o;

    int    tests = 0;
    int    fails = 0;
    beat_t mq [LISTS][$];
    beat_t sb [$];

    listbuffer_param dut (
        .clk(clk), .rst_n(rst_n),
        .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
        .push_index_i(push_index_i), .push_data_i(push_data_i),
        .push_mask_i(push_mask_i), .valid_o(valid_o),
        .pop_valid_i(pop_valid_i), .pop_index_i(pop_index_i),
        .data_o(data_o), .mask_o(mask_o),
        .free_count_o(free_count_o), .pop_err_o(pop_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int total();
        int t = 0;
        for (int l = 0; l < LISTS; l++) t += mq[l].size();
        return t;
    endfunction

    function automatic logic [3:0] vmask();
        logic [3:0] v = '0;
        for (int l = 0; l < LISTS; l++) v[l] = (mq[l].size() > 0);
        return v;
    endfunction

    // Monitor: every accepted pop must match the next scoreboard entry.
    initial forever begin
        beat_t e;
        @(negedge clk);
        #2;
        if (rst_n && pop_valid_i && valid_o[pop_index_i]) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: list %0d", pop_index_i);
            end else begin
                e = sb.pop_front();
                if (data_o !== e.d || mask_o !== e.m) begin
                    fails++;
                    $display("FAIL pop_data: got %0h/%0h expected %0h/%0h",
                             data_o, mask_o, e.d, e.m);
                end
            end
        end
    end

    // Called at a negedge; leaves at the following negedge.
    task automatic step(input bit pv, input int pi, input logic [DW-1:0] pd,
                        input bit ov, input int oi);
        logic [MW-1:0] pm = $urandom;
        bit push_ok, pop_ok, err_exp;
        beat_t b;
        chk("free_count", DW'(free_count_o), DW'(BEATS - total()));
        chk("push_ready", DW'(push_ready_o), DW'(total() < BEATS));
        chk("valid", DW'(valid_o), DW'(vmask()));
        push_ok = pv && total() < BEATS;
        pop_ok  = ov && mq[oi].size() > 0;
        err_exp = ov && !pop_ok;
        if (pop_ok) sb.push_back(mq[oi][0]);
        push_valid_i = pv;
        push_index_i = 2'(pi);
        push_data_i  = pd;
        push_mask_i  = pm;
        pop_valid_i  = ov;
        pop_index_i  = 2'(oi);
        @(posedge clk);
        #1;
        chk("pop_err", DW'(pop_err_o), DW'(err_exp));
        if (pop_ok) void'(mq[oi].pop_front());
        if (push_ok) begin
            b.d = pd;
            b.m = pm;
            mq[pi].push_back(b);
        end
        @(negedge clk);
        push_valid_i = 0;
        pop_valid_i  = 0;
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic do_reset();
        rst_n = 0;
        #1;
        chk("rst_free", DW'(free_count_o), DW'(BEATS));
        chk("rst_ready", DW'(push_ready_o), DW'(1));
        chk("rst_valid", DW'(valid_o), DW'(0));
        chk("rst_err", DW'(pop_err_o), DW'(0));
        chk("rst_data", data_o, DW'(0));
        for (int l = 0; l < LISTS; l++) mq[l].delete();
        sb.delete();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 2, DW'(8'h10 + i), 0, 0);
        step(1, 2, rnd(), 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, rnd(), 1, 2);
        step(1, 0, rnd(), 0, 0);
        step(1, 3, rnd(), 0, 0);
        step(1, 0, rnd(), 0, 0);
        step(1, 3, rnd(), 0, 0);
        step(0, 0, rnd(), 1, 3);
        step(0, 0, rnd(), 1, 3);
        chk("interleave_valid", DW'(valid_o), DW'(4'b0001));
        step(0, 0, rnd(), 1, 0);
        step(0, 0, rnd(), 1, 0);
        step(1, 1, rnd(), 0, 0);
        step(1, 1, DW'(256'hABCD), 1, 1);
        pop_index_i = 1;
        #1;
        chk("same_list_data", data_o, DW'(256'hABCD));
        chk("same_list_valid", DW'(valid_o[1]), DW'(1));
        step(0, 0, rnd(), 1, 1);
        for (int i = 0; i < 8; i++) step(1, 0, rnd(), 0, 0);
        step(1, 0, rnd(), 1, 0);
        step(1, 0, DW'(256'h5A5A), 0, 0);
        step(0, 0, rnd(), 1, 2);
        step(0, 0, rnd(), 0, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 55, $urandom_range(0, 3), rnd(),
                 $urandom_range(0, 99) < 45, $urandom_range(0, 3));
        while (total() > 5) step(0, 0, rnd(), 1, $urandom_range(0, 3));
        while (total() < 5) step(1, $urandom_range(0, 3), rnd(), 0, 0);
        chk("pre_reset_free", DW'(free_count_o), DW'(3));
        #2;
        do_reset();
        for (int i = 0; i < 100; i++)
            step($urandom_range(0, 1), $urandom_range(0, 3), rnd(),
                 $urandom_range(0, 1), $urandom_range(0, 3));
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: %0d entries remain, 0 expected",
                     sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
